// File: rtl/fmul_lrs_normalizer_pkg.sv
// fmul_lrs_normalizer_pkg: shared FPU multiply-path constants, FSM encoding and LRS bit positions.
// The LRS indices are shared with the round-increment logic that consumes {L,R,S}.
package fmul_lrs_normalizer_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_NORM   = 2'd1;
    localparam logic [1:0] ST_DENORM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int LRS_L = 2;
    localparam int LRS_R = 1;
    localparam int LRS_S = 0;

    localparam int F32_BIAS    = 127;
    localparam int F32_EXP_MAX = 255;

    // Leading-zero count of a left-aligned 64-bit field; 64 when empty.
    function automatic logic [6:0] lzc64(input logic [63:0] v);
        logic [6:0] n;
        n = 7'd64;
        for (int i = 0; i < 64; i++) if (v[i]) n = 7'(63 - i);
        return n;
    endfunction

endpackage

// File: rtl/fmul_sticky_shifter.sv
// fmul_sticky_shifter: logical right shift that also reports whether any set bit fell off the end.
// Driven with a constant 1 in the iterative build, with a variable distance in the fast path.
module fmul_sticky_shifter #(
    parameter int W  = 48,
    parameter int SW = 5
) (
    input  logic [W-1:0]  d_i,
    input  logic [SW-1:0] amt_i,
    output logic [W-1:0]  q_o,
    output logic          sticky_o
);

    assign q_o      = d_i >> amt_i;
    assign sticky_o = |(d_i & ~({W{1'b1}} << amt_i));

endmodule

// File: rtl/fmul_lrs_normalizer.sv
// fmul_lrs_normalizer: post-multiply normalize/denormalize producing fraction, exponent and {L,R,S}.
// Define FMUL_NORM_FASTPATH_EN for the single-cycle LZC/barrel-shift NORM and DENORM steps.
module fmul_lrs_normalizer
    import fmul_lrs_normalizer_pkg::*;
#(
    parameter int  FRAC_W     = 23,
    parameter int  EXP_W      = 8,
    parameter int  MAX_RSHIFT = 26,
    localparam int PW         = 2 * (FRAC_W + 1),
    localparam int EW         = EXP_W + 2,
    localparam int SW         = $clog2(MAX_RSHIFT + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [PW-1:0]     product_i,
    input  logic [EW-1:0]     exp_i,
    input  logic              sign_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [FRAC_W-1:0] frac_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic              sign_o,
    output logic [2:0]        lrs_o,
    output logic              tiny_o,
    output logic              ovf_o
);

    localparam logic signed [EW-1:0] E_ONE = EW'(1);
    localparam logic signed [EW-1:0] E_OVF = EW'((1 << EXP_W) - 1);

    logic [1:0]              state_q, state_d;
    logic [PW-1:0]           p_q, p_d;
    logic signed [EW-1:0]    e_q, e_d;
    logic                    sticky_q, sticky_d;
    logic                    tiny_q, tiny_d;
    logic                    sign_q, sign_d;
    logic [FRAC_W-1:0]       frac_q, frac_d;
    logic [EXP_W-1:0]        exp_q, exp_d;
    logic [2:0]              lrs_q, lrs_d;
    logic                    ovf_q, ovf_d;
    logic                    load;
    logic [SW-1:0]           sh_amt;
    logic [PW-1:0]           sh_p;
    logic                    sh_s;

`ifdef FMUL_NORM_FASTPATH_EN
    localparam logic signed [EW:0] RSH_ONE = (EW+1)'(1);
    localparam logic signed [EW:0] RSH_MAX = (EW+1)'(MAX_RSHIFT);
    logic [6:0]           lz;
    logic [EW-1:0]        lsh;
    logic signed [EW:0]   rsh;
    assign lz = lzc64({p_q[PW-2:0], {(65-PW){1'b0}}});
`else
    logic [SW-1:0]        rcnt_q, rcnt_d;
`endif

    fmul_sticky_shifter #(.W(PW), .SW(SW)) u_shift (
        .d_i      (p_q),
        .amt_i    (sh_amt),
        .q_o      (sh_p),
        .sticky_o (sh_s)
    );

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        e_d      = e_q;
        sticky_d = sticky_q;
        tiny_d   = tiny_q;
        sign_d   = sign_q;
        sh_amt   = SW'(1);
`ifdef FMUL_NORM_FASTPATH_EN
        lsh      = '0;
        rsh      = '0;
`else
        rcnt_d   = rcnt_q;
`endif
        case (state_q)
            ST_IDLE: if (valid_i) begin
                p_d      = product_i;
                e_d      = (|product_i) ? $signed(exp_i) : E_ONE - E_ONE;
                sticky_d = 1'b0;
                tiny_d   = 1'b0;
                sign_d   = sign_i;
`ifndef FMUL_NORM_FASTPATH_EN
                rcnt_d   = '0;
`endif
                state_d  = (|product_i) ? ST_NORM : ST_DONE;
            end
`ifdef FMUL_NORM_FASTPATH_EN
            ST_NORM: begin
                if (p_q[PW-1]) begin
                    p_d      = sh_p;
                    sticky_d = sticky_q | sh_s;
                    e_d      = e_q + E_ONE;
                end else if (e_q > E_ONE) begin
                    // Left-normalize, but never below e==1 (gradual underflow).
                    lsh = (EW'(lz) < $unsigned(e_q - E_ONE)) ? EW'(lz) : $unsigned(e_q - E_ONE);
                    p_d = p_q << lsh;
                    e_d = e_q - $signed(lsh);
                end
                state_d = ST_DENORM;
            end
            ST_DENORM: begin
                rsh     = RSH_ONE - $signed({e_q[EW-1], e_q});
                state_d = ST_DONE;
                if (!rsh[EW] && |rsh) begin
                    tiny_d = 1'b1;
                    e_d    = E_ONE;
                    if (rsh > RSH_MAX) begin
                        p_d      = '0;
                        sticky_d = sticky_q | (|p_q);
                    end else begin
                        sh_amt   = SW'(rsh);
                        p_d      = sh_p;
                        sticky_d = sticky_q | sh_s;
                    end
                end
            end
`else
            ST_NORM: begin
                if (p_q[PW-1]) begin
                    p_d      = sh_p;
                    sticky_d = sticky_q | sh_s;
                    e_d      = e_q + E_ONE;
                end else if (!p_q[PW-2] && e_q > E_ONE) begin
                    p_d = p_q << 1;
                    e_d = e_q - E_ONE;
                end else begin
                    state_d = (e_q < E_ONE) ? ST_DENORM : ST_DONE;
                end
            end
            ST_DENORM: begin
                p_d      = sh_p;
                sticky_d = sticky_q | sh_s;
                e_d      = e_q + E_ONE;
                rcnt_d   = rcnt_q + SW'(1);
                tiny_d   = 1'b1;
                if (e_d == E_ONE) begin
                    state_d = ST_DONE;
                end else if (rcnt_d == SW'(MAX_RSHIFT)) begin
                    // Everything left would be shifted out anyway: fold it into sticky.
                    sticky_d = sticky_d | (|sh_p);
                    p_d      = '0;
                    e_d      = E_ONE;
                    state_d  = ST_DONE;
                end
            end
`endif
            default: if (ready_i) state_d = ST_IDLE;
        endcase
    end

    assign load = (state_d == ST_DONE) && (state_q != ST_DONE);

    always_comb begin
        frac_d = frac_q;
        exp_d  = exp_q;
        lrs_d  = lrs_q;
        ovf_d  = ovf_q;
        if (load) begin
            ovf_d        = e_d >= E_OVF;
            frac_d       = ovf_d ? '0 : p_d[PW-3 -: FRAC_W];
            exp_d        = ovf_d ? '1 : (p_d[PW-2] ? e_d[EXP_W-1:0] : '0);
            lrs_d[LRS_L] = p_d[PW-2-FRAC_W];
            lrs_d[LRS_R] = p_d[PW-3-FRAC_W];
            lrs_d[LRS_S] = (|p_d[PW-4-FRAC_W:0]) | sticky_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= ST_IDLE;
            p_q      <= '0;
            e_q      <= '0;
            sticky_q <= 1'b0;
            tiny_q   <= 1'b0;
            sign_q   <= 1'b0;
            frac_q   <= '0;
            exp_q    <= '0;
            lrs_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            e_q      <= e_d;
            sticky_q <= sticky_d;
            tiny_q   <= tiny_d;
            sign_q   <= sign_d;
            frac_q   <= frac_d;
            exp_q    <= exp_d;
            lrs_q    <= lrs_d;
            ovf_q    <= ovf_d;
        end
    end

`ifndef FMUL_NORM_FASTPATH_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) rcnt_q <= '0;
        else          rcnt_q <= rcnt_d;
    end
`endif

    assign ready_o = state_q == ST_IDLE;
    assign valid_o = state_q == ST_DONE;
    assign frac_o  = frac_q;
    assign exp_o   = exp_q;
    assign sign_o  = sign_q;
    assign lrs_o   = lrs_q;
    assign tiny_o  = tiny_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_fmul_lrs_normalizer.sv
// tb_fmul_lrs_normalizer: vector table plus handshake, latency and reset sequences for the normalizer.
module tb_fmul_lrs_normalizer;

    localparam int FRAC_W = 23;
    localparam int EXP_W  = 8;
    localparam int PW     = 48;
    localparam int EW     = 10;
    localparam int NV     = 15;

    logic              clk_i = 1'b0;
    logic              reset_i, valid_i, ready_i, sign_i;
    logic [PW-1:0]     product_i;
    logic [EW-1:0]     exp_i;
    logic              ready_o, valid_o, sign_o, tiny_o, ovf_o;
    logic [FRAC_W-1:0] frac_o;
    logic [EXP_W-1:0]  exp_o;
    logic [2:0]        lrs_o;

    typedef struct {
        logic [PW-1:0]        p;
        logic signed [EW-1:0] e;
        logic                 s;
        logic [FRAC_W-1:0]    f;
        logic [EXP_W-1:0]     x;
        logic [2:0]           lrs;
        logic                 t;
        logic                 o;
    } vec_t;

    vec_t vt[NV];
    vec_t sb[$];
    vec_t mv, vb, vc, vl;
    int   passed = 0;
    int   total  = 0;

    fmul_lrs_normalizer dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .product_i (product_i),
        .exp_i     (exp_i),
        .sign_i    (sign_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .frac_o    (frac_o),
        .exp_o     (exp_o),
        .sign_o    (sign_o),
        .lrs_o     (lrs_o),
        .tiny_o    (tiny_o),
        .ovf_o     (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic send(input vec_t v, input bit track);
        int n = 0;
        while (!ready_o && n < 200) begin
            tick();
            n++;
        end
        if (!ready_o) chk("ready_timeout", ready_o, 1);
        valid_i   = 1'b1;
        product_i = v.p;
        exp_i     = v.e;
        sign_i    = v.s;
        if (track) sb.push_back(v);
        tick();
        valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!valid_o && lat < 200) begin
            tick();
            lat++;
        end
        if (!valid_o) chk("valid_timeout", valid_o, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    // Scoreboard: every completed output handshake must match the oldest expectation.
    always @(negedge clk_i) begin
        if (reset_i === 1'b1 && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", valid_o, 0);
            end else begin
                mv = sb.pop_front();
                chk("frac", frac_o, mv.f);
                chk("exp", exp_o, mv.x);
                chk("lrs", lrs_o, mv.lrs);
                chk("tiny", tiny_o, mv.t);
                chk("ovf", ovf_o, mv.o);
                chk("sign", sign_o, mv.s);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset_i   = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b1;
        product_i = '0;
        exp_i     = '0;
        sign_i    = 1'b0;
        vt[0]  = '{48'h900000000000,  10'sd127, 1'b0, 23'h100000, 8'd128, 3'b000, 1'b0, 1'b0};
        vt[1]  = '{48'h200000000000,  10'sd10,  1'b0, 23'h000000, 8'd9,   3'b000, 1'b0, 1'b0};
        vt[2]  = '{48'h400000000000, -10'sd1,   1'b0, 23'h200000, 8'd0,   3'b000, 1'b1, 1'b0};
        vt[3]  = '{48'h400000000000, -10'sd30,  1'b0, 23'h000000, 8'd0,   3'b001, 1'b1, 1'b0};
        vt[4]  = '{48'h900000000000,  10'sd254, 1'b0, 23'h000000, 8'd255, 3'b000, 1'b0, 1'b1};
        vt[5]  = '{48'h000000000000,  10'sd300, 1'b0, 23'h000000, 8'd0,   3'b000, 1'b0, 1'b0};
        vt[6]  = '{48'h400000C00001,  10'sd127, 1'b0, 23'h000001, 8'd127, 3'b111, 1'b0, 1'b0};
        vt[7]  = '{48'h800000000001,  10'sd100, 1'b0, 23'h000000, 8'd101, 3'b001, 1'b0, 1'b0};
        vt[8]  = '{48'h000000800000,  10'sd3,   1'b0, 23'h000004, 8'd0,   3'b000, 1'b0, 1'b0};
        vt[9]  = '{48'h400000000000, -10'sd25,  1'b0, 23'h000000, 8'd0,   3'b001, 1'b1, 1'b0};
        vt[10] = '{48'h7FFFFFFFFFFF,  10'sd0,   1'b0, 23'h7FFFFF, 8'd0,   3'b111, 1'b1, 1'b0};
        vt[11] = '{48'h400000000000,  10'sd255, 1'b0, 23'h000000, 8'd255, 3'b000, 1'b0, 1'b1};
        vt[12] = '{48'h400000000000,  10'sd254, 1'b0, 23'h000000, 8'd254, 3'b000, 1'b0, 1'b0};
        vt[13] = '{48'h900000000000,  10'sd127, 1'b1, 23'h100000, 8'd128, 3'b000, 1'b0, 1'b0};
        vt[14] = '{48'hC00000000000, -10'sd2,   1'b0, 23'h300000, 8'd0,   3'b000, 1'b1, 1'b0};
        vb     = '{48'h400000000000,  10'sd127, 1'b0, 23'h000000, 8'd127, 3'b000, 1'b0, 1'b0};
        vc     = vt[3];
        vl     = '{48'h000000000001,  10'sd200, 1'b0, 23'h000000, 8'd0,   3'b000, 1'b0, 1'b0};

        tick();
        tick();
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_frac", frac_o, 0);
        chk("rst_exp", exp_o, 0);
        chk("rst_lrs", lrs_o, 0);
        chk("rst_tiny", tiny_o, 0);
        chk("rst_ovf", ovf_o, 0);
        reset_i = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) send(vt[i], 1'b1);
        drain();

        send(vb, 1'b1);
        wait_valid(lat);
        chk("lat_best", lat, 2);
        send(vc, 1'b1);
        wait_valid(lat);
        chk("lat_cap_bound", lat <= PW + 26 + 2, 1);
        drain();

        // Downstream stall with a competing offer that must not be taken.
        ready_i = 1'b0;
        send(vt[0], 1'b1);
        wait_valid(lat);
        valid_i   = 1'b1;
        product_i = 48'h400000000000;
        exp_i     = 10'd100;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", valid_o, 1);
            chk("hold_ready", ready_o, 0);
            chk("hold_frac", frac_o, vt[0].f);
            chk("hold_exp", exp_o, vt[0].x);
            chk("hold_lrs", lrs_o, vt[0].lrs);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (10) tick();
        chk("hold_drained", sb.size(), 0);

        // Reset while NORM is busy left-shifting.
        send(vl, 1'b0);
        tick();
        tick();
        chk("busy_before_reset", ready_o, 0);
        #1 reset_i = 1'b0;
        #1;
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_ready", ready_o, 1);
        chk("mid_rst_frac", frac_o, 0);
        chk("mid_rst_exp", exp_o, 0);
        tick();
        reset_i = 1'b1;
        repeat (60) tick();

        send(vt[6], 1'b1);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fmul_lrs_normalizer.md
Name: fmul_lrs_normalizer

Overview:
Multi-cycle post-multiply normalizer for the FPU multiply path. It takes the raw significand product and the unbiased-sum exponent from the multiplier array. It normalizes or denormalizes the result and emits the truncated fraction, final biased exponent and the L/R/S bit triple. The multiplier's round-increment logic consumes these outputs, so this block is the producer end of the LRS interface. Valid/ready handshake on both sides.

Parameters:
FRAC_W, 23, stored fraction width (23 = binary32). Product width is PW = 2*(FRAC_W+1).
EXP_W, 8, biased exponent field width. The internal exponent is signed, EXP_W+2 bits.
MAX_RSHIFT, 26, denormalizing right-shift cap (FRAC_W+3).

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-low reset
valid_i  in  1  input operand valid
ready_o  out  1  block can accept an operand
product_i  in  PW  significand product; binary point between bits PW-2 and PW-3
exp_i  in  EXP_W+2  signed biased exponent sum (ea+eb-bias)
sign_i  in  1  result sign
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
frac_o  out  FRAC_W  truncated fraction
exp_o  out  EXP_W  biased exponent; 0 means subnormal or zero
sign_o  out  1  result sign, passed through
lrs_o  out  3  {L,R,S} to the round logic
tiny_o  out  1  result was denormalized (sticky-losing shift occurred)
ovf_o  out  1  exponent >= 2^EXP_W-1 after normalization

Behaviour:
- Reset (async, reset_i=0): state IDLE, ready_o=1, valid_o=0, all data outputs 0. Reset mid-operation abandons the operation; no output is produced.
- States: IDLE, NORM, DENORM, DONE. Internal registers: p (PW bits), e (signed), sticky, rcnt.
- IDLE: ready_o=1. On valid_i load p=product_i, e=exp_i, sticky=0, rcnt=0.
  - product_i==0: go to DONE as zero (exp_o=0, frac_o=0, lrs_o=000).
  - Otherwise go to NORM.
- NORM, one action per cycle:
  - p[PW-1]=1: p>>=1, sticky|=shifted-out bit, e+=1. Stay.
  - Else if p[PW-2]=0 and e>1: p<<=1, e-=1. Stay.
  - Else if e<1: go to DENORM.
  - Else: go to DONE.
- DENORM: each cycle p>>=1, sticky|=shifted-out bit, e+=1, rcnt+=1.
  - Exit to DONE when e==1.
  - When rcnt reaches MAX_RSHIFT: sticky|=|p, p=0, e=1, go to DONE.
  - tiny_o=1 if any DENORM shift occurred.
- DONE: valid_o=1, ready_o=0. Outputs are registered and stable until ready_i=1, then return to IDLE.
  - frac_o = p[PW-3:PW-2-FRAC_W]
  - L = p[PW-2-FRAC_W], R = p[PW-3-FRAC_W], S = |p[PW-4-FRAC_W:0] | sticky
  - exp_o = 0 if p[PW-2]=0, else e[EXP_W-1:0]
  - ovf_o = (e >= 2^EXP_W-1); exp_o is then saturated to all ones and frac_o=0.
- No back-to-back acceptance: ready_o is high only in IDLE. An input offered while busy is not taken.
- Worst-case latency is bounded by PW + MAX_RSHIFT + 2 cycles. Best case (already normal): 2 cycles from accept to valid_o.

Optional Feature:
FMUL_NORM_FASTPATH_EN. When defined, NORM and DENORM each complete in one cycle using a leading-zero count and a barrel shifter. Sticky is computed by OR-reducing the shifted-out field. Fixed latency is 3 cycles from accept to valid_o. Outputs are bit-identical to the iterative build. When undefined, the iterative one-bit-per-cycle datapath above is used.

Decomposition:
- Shared FPU package holds:
  - the FSM state encoding;
  - the LRS bit-index localparams (L=2, R=1, S=0), also used by the round logic;
  - binary32 constants: bias 127, EXP_MAX 255.
- One natural sub-module, fmul_sticky_shifter: the right-shift-with-sticky step. It is 1-bit in the iterative build and a barrel shifter in the fast path.

Test Plan:
- 1.5*1.5: product 0x900000000000, exp_i=127 -> frac_o=0x100000, exp_o=128, lrs_o=000, tiny_o=0, ovf_o=0.
- Subnormal input: product 0x200000000000, exp_i=10 -> one left shift; frac_o=0, exp_o=9, lrs_o=000.
- Denormalize: product 0x400000000000, exp_i=-1 -> frac_o=0x200000, exp_o=0, lrs_o=000, tiny_o=1.
- Shift cap: product 0x400000000000, exp_i=-30 -> frac_o=0, exp_o=0, lrs_o=001, tiny_o=1, and valid_o within the latency bound.
- Overflow: product 0x900000000000, exp_i=254 -> ovf_o=1, exp_o=255, frac_o=0.
- Handshake/reset: hold ready_i=0 for 5 cycles in DONE -> outputs stable, ready_o=0. Drop reset_i mid-NORM -> valid_o=0, ready_o=1 immediately. Zero product -> all outputs 0 with valid_o.
